// File: rtl/vga_disc_pkg.sv
// vga_disc_pkg: shared definitions for the disc overlay renderer.
//   cfg_field_e : encodings of the cfg_field port
//   rgb_t       : packed 12-bit {R,G,B} colour
//   PIPE_LAT    : pixel-to-colour latency; sync outputs must be delayed by this
package vga_disc_pkg;
    typedef enum logic [1:0] {
        FLD_CX  = 2'd0,
        FLD_CY  = 2'd1,
        FLD_RAD = 2'd2,
        FLD_COL = 2'd3
    } cfg_field_e;

    typedef logic [11:0] rgb_t;

    localparam int PIPE_LAT = 4;
endpackage

// File: rtl/vga_disc_array_hit.sv
// disc_hit: S1-S3 of the hit test for one disc.
//   clk, reset  : pixel clock, synchronous active-high reset
//   pos_h/pos_v : pixel coordinate (sampled at S1)
//   cx/cy/r     : active disc geometry (sampled at S1 together with the pixel)
//   hit         : registered at S3; 1 when the pixel lies inside the disc
module disc_hit #(
    parameter int COORD_W = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [COORD_W-1:0] pos_h,
    input  logic [COORD_W-1:0] pos_v,
    input  logic [COORD_W-1:0] cx,
    input  logic [COORD_W-1:0] cy,
    input  logic [COORD_W-1:0] r,
    output logic               hit
);
    localparam int SQ_W = 2 * COORD_W;

    logic [COORD_W-1:0] dx, dy, r_s1;
    logic [SQ_W-1:0]    sq_x, sq_y, rr;
    logic               en_s2;

    function automatic logic [SQ_W-1:0] square(input logic [COORD_W-1:0] a);
        return SQ_W'(a) * SQ_W'(a);
    endfunction

    // The radius travels with the pixel so a commit landing mid-flight cannot
    // mix old geometry with a new radius.
    always_ff @(posedge clk) begin
        if (reset) begin
            dx    <= '0;
            dy    <= '0;
            r_s1  <= '0;
            sq_x  <= '0;
            sq_y  <= '0;
            rr    <= '0;
            en_s2 <= 1'b0;
            hit   <= 1'b0;
        end else begin
            dx    <= (pos_h >= cx) ? pos_h - cx : cx - pos_h;
            dy    <= (pos_v >= cy) ? pos_v - cy : cy - pos_v;
            r_s1  <= r;
            sq_x  <= square(dx);
            sq_y  <= square(dy);
            rr    <= square(r_s1);
            // radius 0 would otherwise hit at the exact centre pixel
            en_s2 <= (r_s1 != '0);
            // one extra bit on the sum so it never wraps
            hit   <= en_s2 && (({1'b0, sq_x} + {1'b0, sq_y}) <= {1'b0, rr});
        end
    end
endmodule

// File: rtl/vga_disc_array.sv
// vga_disc_array: multi-disc overlay renderer, one pixel per clock, latency PIPE_LAT.
//   clk, reset          : pixel clock, synchronous active-high reset
//   pos_h, pos_v, blank : pixel from the sync generator
//   cfg_we/disc/field/data : shadow register write port (field encodings in pkg;
//                           geometry uses the low COORD_W bits, COORD_W <= 12)
//   red, green, blue    : registered 4-bit colour outputs
// Shadow sets are copied to the active sets on every edge where (0,0) is sampled.
module vga_disc_array
    import vga_disc_pkg::*;
#(
    parameter int   NUM_DISCS = 4,
    parameter int   COORD_W   = 10,
    parameter rgb_t BG_COLOR  = 12'h0F0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [COORD_W-1:0] pos_h,
    input  logic [COORD_W-1:0] pos_v,
    input  logic               blank,
    input  logic               cfg_we,
    input  logic [2:0]         cfg_disc,
    input  logic [1:0]         cfg_field,
    input  logic [11:0]        cfg_data,
    output logic [3:0]         red,
    output logic [3:0]         green,
    output logic [3:0]         blue
);
    logic [NUM_DISCS-1:0][COORD_W-1:0] cx_sh, cy_sh, r_sh;
    logic [NUM_DISCS-1:0][COORD_W-1:0] cx_ac, cy_ac, r_ac;
    rgb_t [NUM_DISCS-1:0]              col_sh, col_ac;

    // colours and blank follow the pixel through S1..S3
    rgb_t [PIPE_LAT-2:0][NUM_DISCS-1:0] col_pipe;
    logic [PIPE_LAT-2:0]                blank_pipe;
    logic [NUM_DISCS-1:0]               hit;
    rgb_t                               sel, rgb_q;
    logic                               commit;

    assign commit = (pos_h == '0) && (pos_v == '0);

    // Shadow writes and commit share an edge; nonblocking semantics make the
    // commit copy the pre-write shadow value.
    always_ff @(posedge clk) begin
        if (reset) begin
            cx_sh  <= '0;
            cy_sh  <= '0;
            r_sh   <= '0;
            col_sh <= '0;
            cx_ac  <= '0;
            cy_ac  <= '0;
            r_ac   <= '0;
            col_ac <= '0;
        end else begin
            // indices >= NUM_DISCS match no entry and are dropped
            for (int d = 0; d < NUM_DISCS; d++) begin
                if (cfg_we && cfg_disc == 3'(d)) begin
                    case (cfg_field_e'(cfg_field))
                        FLD_CX:  cx_sh[d]  <= cfg_data[COORD_W-1:0];
                        FLD_CY:  cy_sh[d]  <= cfg_data[COORD_W-1:0];
                        FLD_RAD: r_sh[d]   <= cfg_data[COORD_W-1:0];
                        default: col_sh[d] <= cfg_data;
                    endcase
                end
            end
            if (commit) begin
                cx_ac  <= cx_sh;
                cy_ac  <= cy_sh;
                r_ac   <= r_sh;
                col_ac <= col_sh;
            end
        end
    end

    for (genvar d = 0; d < NUM_DISCS; d++) begin : g_disc
        disc_hit #(.COORD_W(COORD_W)) u_hit (
            .clk   (clk),
            .reset (reset),
            .pos_h (pos_h),
            .pos_v (pos_v),
            .cx    (cx_ac[d]),
            .cy    (cy_ac[d]),
            .r     (r_ac[d]),
            .hit   (hit[d])
        );
    end

    // blank resets to 1 so the outputs stay dark while the pipe refills
    always_ff @(posedge clk) begin
        if (reset) begin
            blank_pipe <= '1;
            col_pipe   <= '0;
            rgb_q      <= '0;
        end else begin
            blank_pipe <= {blank_pipe[PIPE_LAT-3:0], blank};
            col_pipe   <= {col_pipe[PIPE_LAT-3:0], col_ac};
            rgb_q      <= blank_pipe[PIPE_LAT-2] ? rgb_t'('0) : sel;
        end
    end

    // lowest index wins: scan from the top so lower hits overwrite
    always_comb begin
        sel = BG_COLOR;
        for (int d = NUM_DISCS - 1; d >= 0; d--) begin
            if (hit[d]) sel = col_pipe[PIPE_LAT-2][d];
        end
    end

    assign {red, green, blue} = rgb_q;
endmodule

// File: tb/tb_vga_disc_array.sv
module tb_vga_disc_array;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  pos_h = '0, pos_v = '0;
    logic        blank = 1'b1;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_disc = '0;
    logic [1:0]  cfg_field = '0;
    logic [11:0] cfg_data = '0;
    logic [3:0]  red, green, blue;

    vga_disc_array #(.NUM_DISCS(4), .COORD_W(10), .BG_COLOR(12'h0F0)) dut (
        .clk(clk), .reset(reset), .pos_h(pos_h), .pos_v(pos_v), .blank(blank),
        .cfg_we(cfg_we), .cfg_disc(cfg_disc), .cfg_field(cfg_field), .cfg_data(cfg_data),
        .red(red), .green(green), .blue(blue)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [11:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   nvec = 0;
    int   nerr = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Drive one pixel for one cycle; the sample edge is the next posedge
    // (counter becomes cyc+1) and the colour is expected 3 edges later.
    task automatic step(input int h, input int v, input logic b,
                        input bit chk, input logic [11:0] exp, input string name);
        pos_h = 10'(h);
        pos_v = 10'(v);
        blank = b;
        if (chk) sb.push_back('{cyc + 1, exp, name});
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_at(input int d, input int f, input logic [11:0] data,
                          input int h, input int v, input logic b,
                          input bit chk, input logic [11:0] exp, input string name);
        cfg_we    = 1'b1;
        cfg_disc  = 3'(d);
        cfg_field = 2'(f);
        cfg_data  = data;
        step(h, v, b, chk, exp, name);
        cfg_we    = 1'b0;
    endtask

    task automatic cfg(input int d, input int f, input logic [11:0] data);
        cfg_at(d, f, data, 5, 5, 1'b1, 1'b0, 12'h000, "");
    endtask

    task automatic disc(input int d, input int x, input int y, input int r, input logic [11:0] c);
        cfg(d, 0, 12'(x));
        cfg(d, 1, 12'(y));
        cfg(d, 2, 12'(r));
        cfg(d, 3, c);
    endtask

    task automatic commit();
        step(0, 0, 1'b1, 1'b1, 12'h000, "commit_blank");
    endtask

    // monitor: compares the scoreboard head when its output slot arrives
    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() > 0 && sb[0].cyc + 3 < cyc) begin
                nvec++;
                nerr++;
                $display("FAIL %s: output slot %0d missed at cycle %0d", sb[0].name, sb[0].cyc + 3, cyc);
                void'(sb.pop_front());
            end
            if (sb.size() > 0 && sb[0].cyc + 3 == cyc) begin
                nvec++;
                if ({red, green, blue} !== sb[0].exp) begin
                    nerr++;
                    $display("FAIL %s: got %h expected %h", sb[0].name, {red, green, blue}, sb[0].exp);
                end
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        // reset held 3 cycles; pixels sampled under reset must render as 0
        step(0, 0, 1'b0, 1'b1, 12'h000, "reset_px0");
        nvec++;
        if ({red, green, blue} !== 12'h000) begin
            nerr++;
            $display("FAIL reset_state: got %h expected 000", {red, green, blue});
        end
        step(0, 0, 1'b0, 1'b1, 12'h000, "reset_px1");
        step(0, 0, 1'b0, 1'b1, 12'h000, "reset_px2");
        reset = 1'b0;

        // empty frame (reduced 40x10 sweep, visible 32x8)
        for (int v = 0; v < 10; v++)
            for (int h = 0; h < 40; h++)
                step(h, v, (h >= 32 || v >= 8), 1'b1,
                     (h >= 32 || v >= 8) ? 12'h000 : 12'h0F0, "empty_frame");

        // single disc boundaries
        disc(0, 320, 240, 10, 12'hF0F);
        commit();
        step(330, 240, 1'b0, 1'b1, 12'hF0F, "edge_right");
        step(320, 230, 1'b0, 1'b1, 12'hF0F, "edge_top");
        step(331, 240, 1'b0, 1'b1, 12'h0F0, "outside_right");
        step(327, 247, 1'b0, 1'b1, 12'hF0F, "diag_98");
        step(328, 247, 1'b0, 1'b1, 12'h0F0, "diag_113");
        step(310, 240, 1'b0, 1'b1, 12'hF0F, "edge_left");
        step(309, 240, 1'b0, 1'b1, 12'h0F0, "outside_left");
        step(320, 251, 1'b0, 1'b1, 12'h0F0, "outside_below");
        step(320, 240, 1'b1, 1'b1, 12'h000, "blank_in_disc");

        // out-of-range writes must not alias onto disc 0
        cfg(4, 3, 12'h123);
        cfg(4, 2, 12'h000);
        cfg(7, 3, 12'h456);
        commit();
        step(320, 240, 1'b0, 1'b1, 12'hF0F, "oob_write_ignored");

        // overlap priority
        disc(0, 100, 100, 20, 12'hF00);
        disc(1, 110, 100, 20, 12'h00F);
        commit();
        step(105, 100, 1'b0, 1'b1, 12'hF00, "overlap_low_wins");
        step(125, 100, 1'b0, 1'b1, 12'h00F, "disc1_only");
        step(80, 100, 1'b0, 1'b1, 12'hF00, "disc0_edge");
        cfg(0, 2, 12'd0);
        commit();
        step(105, 100, 1'b0, 1'b1, 12'h00F, "disc0_disabled");
        cfg(1, 2, 12'd0);
        commit();
        step(100, 100, 1'b0, 1'b1, 12'h0F0, "r0_centre_miss");

        // commit semantics
        cfg(0, 2, 12'd50);
        step(100, 100, 1'b0, 1'b1, 12'h0F0, "midframe_write_hidden");
        commit();
        step(100, 100, 1'b0, 1'b1, 12'hF00, "write_before_commit");
        cfg_at(0, 2, 12'd0, 0, 0, 1'b1, 1'b1, 12'h000, "commit_with_write");
        step(100, 100, 1'b0, 1'b1, 12'hF00, "write_in_commit_deferred");
        commit();
        step(100, 100, 1'b0, 1'b1, 12'h0F0, "write_in_commit_next_frame");

        // extremes, and the commit pixel using pre-commit values
        disc(0, 0, 0, 1023, 12'hFFF);
        commit();
        step(639, 479, 1'b0, 1'b1, 12'hFFF, "far_corner_hit");
        step(1023, 1023, 1'b0, 1'b1, 12'h0F0, "sum_no_overflow");
        cfg(0, 3, 12'h00F);
        step(0, 0, 1'b0, 1'b1, 12'hFFF, "commit_px_old_colour");
        step(1, 1, 1'b0, 1'b1, 12'h00F, "after_commit_new_colour");
        cfg(0, 2, 12'd0);
        step(0, 0, 1'b0, 1'b1, 12'h00F, "commit_px_old_radius");
        step(0, 0, 1'b0, 1'b1, 12'h0F0, "centre_disabled");

        // drain with a bound
        for (int i = 0; i < 10 && sb.size() > 0; i++)
            step(5, 5, 1'b1, 1'b0, 12'h000, "");
        if (sb.size() != 0) begin
            nvec++;
            nerr++;
            $display("FAIL drain: %0d expected outputs never arrived, required 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
